fp32_multiplier: RTL and testbench

- Pipelined IEEE-754 single-precision multiplier; sits directly upstream of adder_32bit in the matrix-multiplier datapath.
- Each element product A[i][k]*B[k][j] goes through this block, and the product then feeds the adder for accumulation.
- Its port style, handshake and special-value conventions match adder_32bit, so its outputs connect straight to adder inputs.
- Fully pipelined: one operation per cycle, fixed latency.

---
 rtl/fp32_multiplier.sv | 144 ++++++++++++++
 tb/tb_fp32_multiplier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_multiplier.sv
// Three-stage IEEE-754 binary32 multiplier. Subnormal inputs and outputs are flushed to zero.
// Rounding is round-to-nearest-even. Handshake and special-value encoding match adder_32bit.
module fp32_multiplier #(
  parameter int unsigned LATENCY = 3,
  parameter logic [31:0] QNAN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_vld,
  output logic [31:0] o_res,
  output logic        o_res_vld,
  output logic        overflow
);

  localparam int unsigned EW = 10;
  localparam int unsigned MW = 24;
  localparam int unsigned PW = 2 * MW;

  // Valid bits for stage 1 and stage 2; o_res_vld is the last stage.
  logic [LATENCY-2:0] vld_pipe;

  // Stage 1: unpack and classify
  logic [7:0]    a_exp_c, b_exp_c;
  logic          a_max_c, b_max_c, a_fnz_c, b_fnz_c;
  logic          nan_c, inf_c, zero_c;
  logic [EW-1:0] exp_sum_c;

  always_comb begin
    a_exp_c   = i_a[30:23];
    b_exp_c   = i_b[30:23];
    a_max_c   = &a_exp_c;
    b_max_c   = &b_exp_c;
    a_fnz_c   = |i_a[22:0];
    b_fnz_c   = |i_b[22:0];
    nan_c     = (a_max_c & a_fnz_c) | (b_max_c & b_fnz_c);
    inf_c     = (a_max_c & ~a_fnz_c) | (b_max_c & ~b_fnz_c);
    zero_c    = ~(|a_exp_c) | ~(|b_exp_c);
    exp_sum_c = EW'(a_exp_c) + EW'(b_exp_c) - EW'(127);
  end

  logic          sign1, nan1, inf1, zero1;
  logic [EW-1:0] exp1;
  logic [MW-1:0] man_a1, man_b1;

  // Stage 2: mantissa product
  logic          sign2, nan2, inf2, zero2;
  logic [EW-1:0] exp2;
  logic [PW-1:0] prod2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sign1    <= 1'b0;
      nan1     <= 1'b0;
      inf1     <= 1'b0;
      zero1    <= 1'b0;
      exp1     <= '0;
      man_a1   <= '0;
      man_b1   <= '0;
      sign2    <= 1'b0;
      nan2     <= 1'b0;
      inf2     <= 1'b0;
      zero2    <= 1'b0;
      exp2     <= '0;
      prod2    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-3:0], i_vld};
      sign1    <= i_a[31] ^ i_b[31];
      nan1     <= nan_c;
      inf1     <= inf_c;
      zero1    <= zero_c;
      exp1     <= exp_sum_c;
      man_a1   <= {1'b1, i_a[22:0]};
      man_b1   <= {1'b1, i_b[22:0]};
      sign2    <= sign1;
      nan2     <= nan1;
      inf2     <= inf1;
      zero2    <= zero1;
      exp2     <= exp1;
      prod2    <= PW'(man_a1) * PW'(man_b1);
    end
  end

  // Stage 3: normalize, round, pack and apply special-case priority
  logic [22:0]   frac_c, frac_fin_c;
  logic          guard_c, round_c, sticky_c, round_up_c;
  logic [EW-1:0] e_norm_c, e_fin_c;
  logic [24:0]   rnd_c;
  logic [31:0]   res_c;
  logic          ovf_c;

  always_comb begin
    frac_c   = prod2[45:23];
    guard_c  = prod2[22];
    round_c  = prod2[21];
    sticky_c = |prod2[20:0];
    e_norm_c = exp2;
    if (prod2[47]) begin
      frac_c   = prod2[46:24];
      guard_c  = prod2[23];
      round_c  = prod2[22];
      sticky_c = |prod2[21:0];
      e_norm_c = exp2 + EW'(1);
    end
    round_up_c = guard_c & (round_c | sticky_c | frac_c[0]);
    rnd_c      = {2'b01, frac_c} + 25'(round_up_c);
    // A carry out of 1.111..1 leaves an all-zero fraction one binade up.
    frac_fin_c = rnd_c[24] ? rnd_c[23:1] : rnd_c[22:0];
    e_fin_c    = e_norm_c + EW'(rnd_c[24]);

    ovf_c = 1'b0;
    if (nan2 || (inf2 && zero2)) begin
      res_c = QNAN;
    end else if (inf2) begin
      res_c = {sign2, 8'hFF, 23'd0};
    end else if (zero2) begin
      res_c = {sign2, 31'd0};
    end else if ($signed(e_fin_c) >= $signed(EW'(255))) begin
      res_c = {sign2, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else if ($signed(e_fin_c) <= $signed(EW'(0))) begin
      res_c = {sign2, 31'd0};
    end else begin
      res_c = {sign2, e_fin_c[7:0], frac_fin_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_res     <= '0;
      o_res_vld <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      o_res_vld <= vld_pipe[LATENCY-2];
      if (vld_pipe[LATENCY-2]) begin
        o_res    <= res_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Self-checking bench for fp32_multiplier: directed vectors plus randomized operands
// checked each cycle against a real-arithmetic reference model.
module tb_fp32_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_vld = 1'b0;
  logic [31:0] o_res;
  logic        o_res_vld;
  logic        overflow;

  fp32_multiplier dut (
    .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_vld(i_vld),
    .o_res(o_res), .o_res_vld(o_res_vld), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;
  logic        last_ovf = 1'b0;
  bit          run = 1'b0;
  exp_t        cur;
  bit          want;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact product in real arithmetic, then one RNE rounding to 24 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    int          ea, eb, e2, fe;
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] ma, mb;
    real         ra, rb, p, scaled, fr;
    longint      n;
    logic [63:0] bits;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    o = 1'b0;
    if (a_nan || b_nan) r = 32'h7FC00000;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) r = 32'h7FC00000;
    else if (a_inf || b_inf) r = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero) r = {s, 31'd0};
    else begin
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      ra = ma;
      rb = mb;
      p  = ra * rb * (2.0 ** real'(ea + eb - 300));
      bits = $realtobits(p);
      e2 = int'(bits[62:52]) - 1023;
      scaled = p * (2.0 ** real'(23 - e2));
      n  = longint'($floor(scaled));
      fr = scaled - real'(n);
      if (fr > 0.5 || (fr == 0.5 && n[0])) n = n + 1;
      fe = e2 + 127;
      if (n == (64'sd1 << 24)) begin
        n  = 64'sd1 << 23;
        fe = fe + 1;
      end
      if (fe >= 255) begin
        r = {s, 8'hFF, 23'd0};
        o = 1'b1;
      end else if (fe <= 0) r = {s, 31'd0};
      else r = {s, 8'(fe), n[22:0]};
    end
  endfunction

  // Per-cycle compare: pulse presence, result value and held value.
  initial forever begin
    @(posedge clk);
    #1;
    if (run) begin
      want = (q.size() > 0) && (q[0].due == cyc);
      checks++;
      if (o_res_vld !== want) begin
        errors++;
        $display("FAIL o_res_vld cyc=%0d got %b want %b", cyc, o_res_vld, want);
      end
      if (want) begin
        cur = q.pop_front();
        last_res = cur.res;
        last_ovf = cur.ovf;
      end
      checks++;
      if (o_res !== last_res) begin
        errors++;
        $display("FAIL o_res cyc=%0d got %h want %h", cyc, o_res, last_res);
      end
      checks++;
      if (overflow !== last_ovf) begin
        errors++;
        $display("FAIL overflow cyc=%0d got %b want %b", cyc, overflow, last_ovf);
      end
    end
  end

  task automatic push_exp(input logic [31:0] r, input logic o);
    exp_t e;
    e.due = cyc + 3;
    e.res = r;
    e.ovf = o;
    q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o);
    @(negedge clk);
    i_a   = a;
    i_b   = b;
    i_vld = 1'b1;
    push_exp(r, o);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_vld = 1'b0;
      i_a   = $urandom;
      i_b   = $urandom;
    end
  endtask

  // Directed vector with a hand-computed expectation that also pins the model.
  task automatic lit(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic o);
    logic [31:0] mr;
    logic        mo;
    model(a, b, mr, mo);
    checks++;
    if (mr !== r || mo !== o) begin
      errors++;
      $display("FAIL model %h*%h got %h/%b want %h/%b", a, b, mr, mo, r, o);
    end
    drive(a, b, r, o);
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3, 4:    v[30:23] = 8'($urandom_range(1, 40));
      5, 6:    v[30:23] = 8'($urandom_range(215, 254));
      7:       v[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 3));
      8, 9:    v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic        o;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    lit(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    idle(5);
    lit(32'hBFC00000, 32'h40880000, 32'hC0CC0000, 1'b0);
    idle(4);
    lit(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
    lit(32'h7FC00000, 32'h40000000, 32'h7FC00000, 1'b0);
    lit(32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0);
    lit(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0);
    idle(4);
    lit(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
    lit(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0);
    lit(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0);
    lit(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0);
    lit(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0);
    lit(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);
    idle(4);

    // Reset with two operations in flight and a third presented during reset.
    lit(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    lit(32'h40400000, 32'h40400000, 32'h41100000, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    i_vld    = 1'b1;
    q.delete();
    last_res = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    i_vld = 1'b0;
    idle(5);
    lit(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      a = gen_op();
      b = gen_op();
      model(a, b, r, o);
      drive(a, b, r, o);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    idle(2);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
